// File: rtl/div_radix2.sv
// Multi-cycle 32/32 restoring radix-2 divider, signed or unsigned, result = {remainder, quotient}.
// Optional build macro DIV_SMALL_DIVIDEND_EN: finish at once when |dividend| < |divisor|.
module div_radix2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DBZ  = 2'd1,
        ST_ON   = 2'd2,
        ST_END  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] sr_q, sr_d;
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        dvd_neg_q, dvd_neg_d;
    logic        dvs_neg_q, dvs_neg_d;
    logic [63:0] result_q, result_d;

    logic        dvd_neg_in;
    logic        dvs_neg_in;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic [64:0] sr_shift;
    logic [32:0] trial;
    logic [32:0] trial_diff;
    logic        trial_fits;
    logic [64:0] sr_iter;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes; the most negative value maps to itself, which is its correct unsigned magnitude.
    always_comb begin
        dvd_neg_in = signed_div_i & opdata1_i[31];
        dvs_neg_in = signed_div_i & opdata2_i[31];
        dvd_abs    = dvd_neg_in ? (32'd0 - opdata1_i) : opdata1_i;
        dvs_abs    = dvs_neg_in ? (32'd0 - opdata2_i) : opdata2_i;
    end

    // One restoring step: upper 33 bits hold the partial remainder, lower 32 shift dividend out / quotient in.
    always_comb begin
        sr_shift   = {sr_q[63:0], 1'b0};
        trial      = sr_shift[64:32];
        trial_fits = (trial >= {1'b0, divisor_q});
        trial_diff = trial - {1'b0, divisor_q};
        sr_iter    = trial_fits ? {trial_diff, sr_shift[31:1], 1'b1} : sr_shift;
        quot_raw   = sr_iter[31:0];
        rem_raw    = sr_iter[63:32];
        quot_fix   = (signed_q & (dvd_neg_q ^ dvs_neg_q)) ? (32'd0 - quot_raw) : quot_raw;
        rem_fix    = (signed_q & dvd_neg_q) ? (32'd0 - rem_raw) : rem_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    signed_d  = signed_div_i;
                    dvd_neg_d = dvd_neg_in;
                    dvs_neg_d = dvs_neg_in;
                    divisor_d = dvs_abs;
                    sr_d      = {33'd0, dvd_abs};
                    cnt_d     = 6'd0;
                    result_d  = 64'd0;
                    if (opdata2_i == 32'd0) begin
                        state_d = ST_DBZ;
                    end
`ifdef DIV_SMALL_DIVIDEND_EN
                    else if (dvd_abs < dvs_abs) begin
                        state_d  = ST_END;
                        result_d = {opdata1_i, 32'd0};
                    end
`endif
                    else begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_DBZ: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_END;
                    result_d = 64'd0;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    sr_d  = sr_iter;
                    cnt_d = cnt_q + 6'd1;
                    // Counter value 31 means this edge performs the 32nd iteration.
                    if (cnt_q == 6'd31) begin
                        state_d  = ST_END;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            ST_END: begin
                if (annul_i || !start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            sr_q      <= 65'd0;
            divisor_q <= 32'd0;
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = (state_q == ST_END);
    assign result_o = ready_o ? result_q : 64'd0;

endmodule

// File: tb/tb_div_radix2.sv
// Randomized and directed bench for div_radix2 against an arithmetic reference model.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    div_radix2 dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint as_int(input bit sgn, input logic [31:0] x);
        longint v;
        if (sgn) v = longint'($signed(x));
        else     v = longint'({32'd0, x});
        return v;
    endfunction

    function automatic longint mag(input bit sgn, input logic [31:0] x);
        longint v;
        v = as_int(sgn, x);
        return (v < 0) ? -v : v;
    endfunction

    // Truncating division on 64-bit integers, keeping the low 32 bits of each result.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 32'd0) return 64'd0;
        la = as_int(sgn, a);
        lb = as_int(sgn, b);
        q  = la / lb;
        r  = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        bit early;
`ifdef DIV_SMALL_DIVIDEND_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        if (b == 32'd0) return 1;
        if (early && (mag(sgn, a) < mag(sgn, b))) return 0;
        return 32;
    endfunction

    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit scramble, input string tag);
        logic [63:0] exp;
        int          want;
        int          n;
        exp  = model(sgn, a, b);
        want = exp_lat(sgn, a, b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        if (scramble) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
        end
        if (want > 0) check({tag, " busy_res"}, result_o, 64'd0);
        n = 0;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(want));
        check({tag, " result"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold_rdy"}, 64'(ready_o), 64'd1);
            check({tag, " hold_res"}, result_o, exp);
        end
        start_i = 1'b0;
        tick();
        check({tag, " drop_rdy"}, 64'(ready_o), 64'd0);
        check({tag, " drop_res"}, result_o, 64'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        check({tag, " reached_ready"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        bit          seen;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          mode;

        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
        start_i = 1'b0; annul_i = 1'b0;
        tick();
        tick();
        check("reset rdy", 64'(ready_o), 64'd0);
        check("reset res", result_o, 64'd0);
        rst = 1'b0;
        tick();

        run_op(1'b0, 32'd100, 32'd7, 5, 1'b1, "u100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "s-7_2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b1, "s_min_m1");
        run_op(1'b0, 32'd5, 32'd9, 0, 1'b0, "u5_9");
        run_op(1'b1, 32'hFFFF_FFFB, 32'd9, 0, 1'b0, "s-5_9");
        run_op(1'b0, 32'd1234, 32'd0, 2, 1'b1, "dbz_u");
        run_op(1'b1, 32'h8000_0000, 32'd0, 0, 1'b0, "dbz_s");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "u_max_1");

        // Annul ten cycles into the iteration phase.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        repeat (10) tick();
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        check("annul_on rdy", 64'(ready_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen |= ready_o;
        end
        check("annul_on no_pulse", 64'(seen), 64'd0);
        run_op(1'b0, 32'd100, 32'd7, 0, 1'b0, "after_annul");

        // Reset ten cycles into the iteration phase.
        opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        repeat (10) tick();
        rst = 1'b1; start_i = 1'b0;
        tick();
        check("rst_on rdy", 64'(ready_o), 64'd0);
        check("rst_on res", result_o, 64'd0);
        rst = 1'b0;
        tick();
        run_op(1'b0, 32'd100, 32'd7, 0, 1'b0, "after_rst");

        // Annul while parked in the result state with start still held.
        opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        tick();
        wait_ready("annul_end");
        annul_i = 1'b1;
        tick();
        check("annul_end rdy", 64'(ready_o), 64'd0);
        check("annul_end res", result_o, 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        tick();

        // Reset while parked in the result state.
        opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        tick();
        wait_ready("rst_end");
        rst = 1'b1;
        tick();
        check("rst_end rdy", 64'(ready_o), 64'd0);
        check("rst_end res", result_o, 64'd0);
        rst = 1'b0; start_i = 1'b0;
        tick();

        // Annul during the divide-by-zero cycle: no result pulse.
        opdata1_i = 32'd9; opdata2_i = 32'd0; start_i = 1'b1;
        tick();
        annul_i = 1'b1;
        tick();
        check("annul_dbz rdy", 64'(ready_o), 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        tick();
        check("annul_dbz idle", 64'(ready_o), 64'd0);

        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 3);
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            case (mode)
                1: b = $urandom_range(1, 300);
                2: begin a = $urandom_range(0, 50); b = $urandom_range(51, 1000); end
                3: b = (k % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(sgn, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div_radix2.md
DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 signed_div_i  input  1  1 = signed (two's complement) division, 0 = unsigned; sampled with start.
REQ-005 opdata1_i  input  32  dividend; sampled with start.
REQ-006 opdata2_i  input  32  divisor; sampled with start.
REQ-007 start_i  input  1  initiator request; held high by initiator until ready_o seen.
REQ-008 annul_i  input  1  abort in-flight operation.
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1, else 0.
REQ-010 ready_o  output  1  result valid.

Function
REQ-011 FSM states SHALL be IDLE, DBZ, ON, END; 6-bit iteration counter; 65-bit partial-remainder/quotient shift register; latched divisor, sign flags.
REQ-012 IDLE: start_i=1, annul_i=0 at edge E0 -> latch operands and signed_div_i; divisor==0 -> DBZ; else -> ON with counter=0; otherwise stay IDLE.
REQ-013 Signed mode: operands SHALL be converted to magnitudes at latch time; unsigned mode uses raw values.
REQ-014 ON: one restoring iteration per edge (shift left 1, trial-subtract divisor, set quotient bit if non-negative); counter increments; the edge performing iteration 32 SHALL transition to END, so END is entered at E0+32.
REQ-015 Final sign fix on entry to END: quotient negated if signed and operand signs differ; remainder negated if signed and dividend negative.
REQ-016 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no exception).
REQ-017 DBZ: next edge -> END with result 0 (END at E0+1).
REQ-018 END: ready_o=1, result_o=latched result; stay in END while start_i=1; start_i=0 -> IDLE next edge.
REQ-019 ready_o and result_o SHALL be 0 in IDLE, DBZ, ON.
REQ-020 annul_i=1 in ON, DBZ or END -> IDLE next edge, no ready_o pulse; annul_i has priority over start_i.
REQ-021 start_i deasserted or operand inputs changing during ON/DBZ SHALL NOT affect the operation (latched copies used).
REQ-022 Initiator dropping start_i combinationally on ready_o SHALL produce a one-cycle ready_o pulse.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, clear counter, shift register, latched operands and result; ready_o=0, result_o=0 from that edge, including mid-operation.
REQ-024 rst SHALL have priority over start_i and annul_i.

Configuration
REQ-025 Macro DIV_SMALL_DIVIDEND_EN SHALL enable early exit: in IDLE, nonzero divisor and |dividend| < |divisor| -> END directly at E0 with quotient 0, remainder = dividend (original sign).
REQ-026 Without DIV_SMALL_DIVIDEND_EN, all nonzero-divisor operations SHALL take full 32 iterations; result values SHALL be identical in both builds.

Verification
REQ-027 Unsigned 100/7, start held -> ready_o at E0+32, result_o = {32'd2, 32'd14}; drop start -> ready_o=0 next cycle.
REQ-028 Signed -7/2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
REQ-029 Divisor 0 -> ready_o at E0+1, result_o = 0.
REQ-030 annul_i pulsed 10 cycles into ON -> no ready_o, IDLE; new start 100/7 then completes correctly; same with rst mid-ON -> outputs 0 immediately.
REQ-031 start held 5 cycles after ready -> ready_o stays 1, result stable; operands changed during ON -> result unchanged.
REQ-032 Unsigned 5/9 with DIV_SMALL_DIVIDEND_EN -> ready_o at E0, result_o = {32'd5, 32'd0}; without macro -> ready_o at E0+32, same result.
